hazard_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_fwd_sel.sv | 30 +++
 rtl/hazard_unit.sv | 176 +++++++++++++++++
 tb/tb_hazard_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
//   fwd_sel_e   : Execute operand mux select (register file / write-back / memory)
//   mem_state_e : data-memory wait tracker state
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// One Execute-operand forwarding select.
//   rs_e          : Execute source register being resolved
//   rd_m, wen_m   : Memory-stage destination and write enable
//   rd_w, wen_w   : Write-back destination and write enable
//   fwd_sel       : FWD_MEM / FWD_WB / FWD_REG
// The Memory stage holds the younger result, so it wins over Write-back.
// x0 is hard-wired zero and is never forwarded.
module hazard_fwd_sel
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs_e,
   input  logic [REG_ADDR_W-1:0] rd_m,
   input  logic                  wen_m,
   input  logic [REG_ADDR_W-1:0] rd_w,
   input  logic                  wen_w,
   output fwd_sel_e              fwd_sel
);

   always_comb begin
      fwd_sel = FWD_REG;
      if (wen_m && (rd_m != '0) && (rd_m == rs_e)) begin
         fwd_sel = FWD_MEM;
      end else if (wen_w && (rd_w != '0) && (rd_w == rs_e)) begin
         fwd_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage RV32I core.
//   Inputs : Decode/Execute source and destination registers, stage write
//            enables, Execute load flag, branch mispredict, Memory-stage
//            request and LSU ready.
//   Outputs: forward_A_E / forward_B_E operand selects, per-stage stall and
//            flush controls, sticky mem_timeout_err, and saturating
//            performance counters (stall cycles, load-use stalls, flushes).
//
//   state | meaning
//   RUN   | no outstanding data-memory wait
//   WAIT  | Memory stage frozen on an LSU request that has not completed
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [REG_ADDR_W-1:0] rs1_addr_D,
   input  logic [REG_ADDR_W-1:0] rs2_addr_D,
   input  logic [REG_ADDR_W-1:0] rs1_addr_E,
   input  logic [REG_ADDR_W-1:0] rs2_addr_E,
   input  logic [REG_ADDR_W-1:0] rd_addr_E,
   input  logic                  is_load_E,
   input  logic [REG_ADDR_W-1:0] rd_addr_M,
   input  logic                  reg_wen_M,
   input  logic [REG_ADDR_W-1:0] rd_addr_W,
   input  logic                  reg_wen_W,
   input  logic                  mispredict_E,
   input  logic                  mem_req_M,
   input  logic                  lsu_ready_M,
   output logic [1:0]            forward_A_E,
   output logic [1:0]            forward_B_E,
   output logic                  stall_F,
   output logic                  stall_D,
   output logic                  stall_E,
   output logic                  stall_M,
   output logic                  stall_W,
   output logic                  flush_D,
   output logic                  flush_E,
   output logic                  mem_timeout_err,
   output logic [CNT_W-1:0]      stall_cyc_cnt,
   output logic [CNT_W-1:0]      lu_stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   fwd_sel_e fwd_a;
   fwd_sel_e fwd_b;

   hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .rs_e    (rs1_addr_E),
      .rd_m    (rd_addr_M),
      .wen_m   (reg_wen_M),
      .rd_w    (rd_addr_W),
      .wen_w   (reg_wen_W),
      .fwd_sel (fwd_a)
   );

   hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .rs_e    (rs2_addr_E),
      .rd_m    (rd_addr_M),
      .wen_m   (reg_wen_M),
      .rd_w    (rd_addr_W),
      .wen_w   (reg_wen_W),
      .fwd_sel (fwd_b)
   );

   assign forward_A_E = fwd_a;
   assign forward_B_E = fwd_b;

   logic freeze;
   logic lu_hazard;
   logic lu_stall;

   assign freeze    = mem_req_M && !lsu_ready_M;
   assign lu_hazard = is_load_E && (rd_addr_E != '0) &&
                      ((rd_addr_E == rs1_addr_D) || (rd_addr_E == rs2_addr_D));
   // A frozen pipeline holds the hazard in place; it is acted on once the
   // freeze lifts. A mispredict squashes the wrong-path Decode instruction,
   // so there is nothing left to stall for.
   assign lu_stall  = !freeze && !mispredict_E && lu_hazard;

   always_comb begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      stall_E = 1'b0;
      stall_M = 1'b0;
      stall_W = 1'b0;
      flush_D = 1'b0;
      flush_E = 1'b0;
      if (freeze) begin
         stall_F = 1'b1;
         stall_D = 1'b1;
         stall_E = 1'b1;
         stall_M = 1'b1;
         stall_W = 1'b1;
      end else if (mispredict_E) begin
         flush_D = 1'b1;
         flush_E = 1'b1;
      end else if (lu_hazard) begin
         stall_F = 1'b1;
         stall_D = 1'b1;
         flush_E = 1'b1;
      end
   end

   mem_state_e        state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  stall_cyc_q, stall_cyc_d;
   logic [CNT_W-1:0]  lu_stall_q, lu_stall_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
      case (state_q)
         RUN: begin
            wait_cnt_d = '0;
            if (freeze) state_d = WAIT;
         end
         WAIT: begin
            if (!freeze) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else begin
               if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
               if (wait_cnt_d == WAIT_MAX) err_d = 1'b1;
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      stall_cyc_d = stall_cyc_q;
      lu_stall_d  = lu_stall_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_F && (stall_cyc_q != '1)) stall_cyc_d = stall_cyc_q + 1'b1;
      if (lu_stall && (lu_stall_q != '1)) lu_stall_d = lu_stall_q + 1'b1;
      if (flush_D && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
         stall_cyc_q <= '0;
         lu_stall_q  <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
         stall_cyc_q <= stall_cyc_d;
         lu_stall_q  <= lu_stall_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign mem_timeout_err = err_q;
   assign stall_cyc_cnt   = stall_cyc_q;
   assign lu_stall_cnt    = lu_stall_q;
   assign flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: each step drives one input vector just
// after the rising edge and queues the hand-computed response; the monitor
// pops and compares on the falling edge. Counter expectations accumulate
// from the expected stall/flush pattern of previous steps.
module tb_hazard_unit;

   localparam int AW = 5;
   localparam int CW = 8;
   localparam int TO = 4;

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
      logic          ld_e;
      logic [AW-1:0] rd_m;
      logic          wen_m;
      logic [AW-1:0] rd_w;
      logic          wen_w;
      logic          mis, req, rdy;
   } in_t;

   typedef struct {
      int            id;
      logic [1:0]    fa, fb;
      logic [4:0]    st;
      logic [1:0]    fl;
      logic          err, err_chk;
      logic [CW-1:0] sc, lc, fc;
   } exp_t;

   function automatic in_t zero_in();
      in_t z;
      z.rs1_d = '0; z.rs2_d = '0; z.rs1_e = '0; z.rs2_e = '0; z.rd_e = '0;
      z.ld_e  = 1'b0; z.rd_m = '0; z.wen_m = 1'b0; z.rd_w = '0; z.wen_w = 1'b0;
      z.mis   = 1'b0; z.req = 1'b0; z.rdy = 1'b0;
      return z;
   endfunction

   in_t cur = zero_in();
   in_t nx  = zero_in();

   logic [1:0]    fa, fb;
   logic          st_f, st_d, st_e, st_m, st_w, fl_d, fl_e, err;
   logic [CW-1:0] sc, lc, fc;

   hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .rs1_addr_D      (cur.rs1_d),
      .rs2_addr_D      (cur.rs2_d),
      .rs1_addr_E      (cur.rs1_e),
      .rs2_addr_E      (cur.rs2_e),
      .rd_addr_E       (cur.rd_e),
      .is_load_E       (cur.ld_e),
      .rd_addr_M       (cur.rd_m),
      .reg_wen_M       (cur.wen_m),
      .rd_addr_W       (cur.rd_w),
      .reg_wen_W       (cur.wen_w),
      .mispredict_E    (cur.mis),
      .mem_req_M       (cur.req),
      .lsu_ready_M     (cur.rdy),
      .forward_A_E     (fa),
      .forward_B_E     (fb),
      .stall_F         (st_f),
      .stall_D         (st_d),
      .stall_E         (st_e),
      .stall_M         (st_m),
      .stall_W         (st_w),
      .flush_D         (fl_d),
      .flush_E         (fl_e),
      .mem_timeout_err (err),
      .stall_cyc_cnt   (sc),
      .lu_stall_cnt    (lc),
      .flush_cnt       (fc)
   );

   exp_t          sb_q[$];
   int            errors  = 0;
   int            checks  = 0;
   int            step_id = 0;
   logic [CW-1:0] m_sc = '0, m_lc = '0, m_fc = '0;
   exp_t          last;
   logic          last_valid = 1'b0;

   function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   task automatic step(input logic rst, input logic [1:0] fa_x, input logic [1:0] fb_x,
                       input logic [4:0] st_x, input logic [1:0] fl_x,
                       input logic err_x, input logic err_c);
      exp_t e;
      @(posedge i_clk);
      #1;
      // i_rst_n still holds the level seen at that edge
      if (i_rst_n && last_valid) begin
         if (last.st[4])                m_sc = sat(m_sc);
         if (last.st[4] && !last.st[0]) m_lc = sat(m_lc);
         if (last.fl[1])                m_fc = sat(m_fc);
      end
      i_rst_n = rst;
      cur     = nx;
      if (!rst) begin
         m_sc = '0; m_lc = '0; m_fc = '0;
      end
      step_id++;
      e.id = step_id; e.fa = fa_x; e.fb = fb_x; e.st = st_x; e.fl = fl_x;
      e.err = err_x; e.err_chk = err_c; e.sc = m_sc; e.lc = m_lc; e.fc = m_fc;
      sb_q.push_back(e);
      last       = e;
      last_valid = 1'b1;
   endtask

   task automatic chk(input string name, input int id, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
      end
   endtask

   exp_t me;
   always @(negedge i_clk) begin
      if (sb_q.size() > 0) begin
         me = sb_q.pop_front();
         chk("forward_A_E", me.id, 32'(fa), 32'(me.fa));
         chk("forward_B_E", me.id, 32'(fb), 32'(me.fb));
         chk("stalls_FDEMW", me.id, 32'({st_f, st_d, st_e, st_m, st_w}), 32'(me.st));
         chk("flush_DE", me.id, 32'({fl_d, fl_e}), 32'(me.fl));
         if (me.err_chk) chk("mem_timeout_err", me.id, 32'(err), 32'(me.err));
         chk("stall_cyc_cnt", me.id, 32'(sc), 32'(me.sc));
         chk("lu_stall_cnt", me.id, 32'(lc), 32'(me.lc));
         chk("flush_cnt", me.id, 32'(fc), 32'(me.fc));
      end
   end

   initial begin
      // reset, then idle
      step(1'b0, 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b1);
      step(1'b1, 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b1);

      // forwarding priority and x0
      nx.rs1_e = 5; nx.rs2_e = 5; nx.rd_m = 5; nx.wen_m = 1; nx.rd_w = 5; nx.wen_w = 1;
      step(1'b1, 2'b10, 2'b10, 5'b00000, 2'b00, 1'b0, 1'b1);
      nx.wen_m = 0;
      step(1'b1, 2'b01, 2'b01, 5'b00000, 2'b00, 1'b0, 1'b1);
      nx.wen_m = 1; nx.rd_m = 0; nx.rd_w = 0;
      step(1'b1, 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b1);
      nx.rd_m = 5; nx.rd_w = 6; nx.rs2_e = 6;
      step(1'b1, 2'b10, 2'b01, 5'b00000, 2'b00, 1'b0, 1'b1);
      nx.wen_w = 0;
      step(1'b1, 2'b10, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b1);

      // load-use on rs2, then the load in M forwards
      nx = zero_in();
      nx.ld_e = 1; nx.rd_e = 7; nx.rs2_d = 7;
      step(1'b1, 2'b00, 2'b00, 5'b11000, 2'b01, 1'b0, 1'b1);
      nx = zero_in();
      nx.rd_m = 7; nx.wen_m = 1; nx.rs2_e = 7;
      step(1'b1, 2'b00, 2'b10, 5'b00000, 2'b00, 1'b0, 1'b1);
      // load-use on rs1
      nx.ld_e = 1; nx.rd_e = 3; nx.rs1_d = 3;
      step(1'b1, 2'b00, 2'b10, 5'b11000, 2'b01, 1'b0, 1'b1);
      // load to x0 and non-load producer: no stall
      nx = zero_in();
      nx.ld_e = 1;
      step(1'b1, 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b1);
      nx.ld_e = 0; nx.rd_e = 4; nx.rs1_d = 4;
      step(1'b1, 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b1);

      // mispredict overrides load-use
      nx = zero_in();
      nx.ld_e = 1; nx.rd_e = 7; nx.rs2_d = 7; nx.mis = 1;
      step(1'b1, 2'b00, 2'b00, 5'b00000, 2'b11, 1'b0, 1'b1);

      // freeze dominates mispredict and load-use for 3 cycles, then release
      nx.req = 1; nx.rdy = 0;
      repeat (3) step(1'b1, 2'b00, 2'b00, 5'b11111, 2'b00, 1'b0, 1'b1);
      nx.rdy = 1;
      step(1'b1, 2'b00, 2'b00, 5'b00000, 2'b11, 1'b0, 1'b1);
      nx = zero_in();
      step(1'b1, 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b1);

      // timeout: freeze for 6 cycles
      nx.req = 1;
      repeat (3) step(1'b1, 2'b00, 2'b00, 5'b11111, 2'b00, 1'b0, 1'b1);
      repeat (2) step(1'b1, 2'b00, 2'b00, 5'b11111, 2'b00, 1'b0, 1'b0);
      step(1'b1, 2'b00, 2'b00, 5'b11111, 2'b00, 1'b1, 1'b1);
      nx.req = 0;
      repeat (2) step(1'b1, 2'b00, 2'b00, 5'b00000, 2'b00, 1'b1, 1'b1);

      // reset in the middle of a wait
      nx.req = 1; nx.rs1_e = 9; nx.rd_w = 9; nx.wen_w = 1;
      repeat (2) step(1'b1, 2'b01, 2'b00, 5'b11111, 2'b00, 1'b1, 1'b1);
      step(1'b0, 2'b01, 2'b00, 5'b11111, 2'b00, 1'b0, 1'b1);
      nx.req = 0;
      step(1'b0, 2'b01, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b1);
      step(1'b1, 2'b01, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b1);
      nx.req = 1;
      step(1'b1, 2'b01, 2'b00, 5'b11111, 2'b00, 1'b0, 1'b1);
      nx = zero_in();
      step(1'b1, 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b1);

      // flush_cnt saturates rather than wrapping
      nx.mis = 1;
      repeat (260) step(1'b1, 2'b00, 2'b00, 5'b00000, 2'b11, 1'b0, 1'b1);
      nx = zero_in();
      step(1'b1, 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b1);

      for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge i_clk);
      #1;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
